// File: rtl/sat_pkg.sv
// Shared encodings for the SAT-solver clause array.
// Variable values, literal codes and free-literal counts.
package sat_pkg;

  localparam logic [1:0] VAL_FREE     = 2'b00;
  localparam logic [1:0] VAL_FALSE    = 2'b01;
  localparam logic [1:0] VAL_TRUE     = 2'b10;
  localparam logic [1:0] VAL_CONFLICT = 2'b11;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_NEG  = 2'b01;
  localparam logic [1:0] LIT_POS  = 2'b10;

  localparam logic [1:0] CNT_ZERO = 2'b00;
  localparam logic [1:0] CNT_ONE  = 2'b01;
  localparam logic [1:0] CNT_MANY = 2'b11;

  // Saturating free-literal count: zero->one, anything else->many.
  function automatic logic [1:0] freecnt_inc(input logic [1:0] pre);
    return {pre[1] | pre[0], 1'b1};
  endfunction

endpackage

// File: rtl/lit_cell.sv
// One literal slot of a clause row: polarity storage,
// free-count chaining, satisfaction, implication and conflict flags.
module lit_cell
  import sat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_i,
  input  logic [2:0] var_value_i,
  output logic [2:0] var_value_o,
  input  logic [1:0] freelitcnt_pre,
  output logic [1:0] freelitcnt_next,
  input  logic       imp_drv_i,
  input  logic       cclause_drv_i,
  output logic       cclause_o,
  output logic       clausesat_o
);

  logic [1:0] r_lit;
  logic [1:0] w_v;
  logic       w_has;
  logic       w_true;
  logic       w_free;
  logic       w_unused;

  assign w_v      = var_value_i[2:1];
  assign w_unused = var_value_i[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lit <= LIT_NONE;
    end else if (wr_i) begin
      // Code 11 is not a literal; store it as empty.
      r_lit <= (w_v == VAL_CONFLICT) ? LIT_NONE : w_v;
    end
  end

  assign w_has  = (r_lit != LIT_NONE);
  assign w_true = w_has && (w_v == r_lit);
  assign w_free = w_has && (w_v == VAL_FREE);

  assign freelitcnt_next = w_free ? freecnt_inc(freelitcnt_pre)
                                  : freelitcnt_pre;
  assign clausesat_o     = w_true;
  assign var_value_o     = (imp_drv_i && w_free) ? {r_lit, 1'b1}
                                                 : 3'b000;
  assign cclause_o       = cclause_drv_i & w_has;

endmodule

// File: tb/tb_lit_cell.sv
// Directed table-driven bench for lit_cell.
// Each row: inputs applied, outputs checked before the next edge.
module tb_lit_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_i;
  logic [2:0] var_value_i;
  logic [2:0] var_value_o;
  logic [1:0] freelitcnt_pre;
  logic [1:0] freelitcnt_next;
  logic       imp_drv_i;
  logic       cclause_drv_i;
  logic       cclause_o;
  logic       clausesat_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lit_cell dut (
    .clk            (clk),
    .rst            (rst),
    .wr_i           (wr_i),
    .var_value_i    (var_value_i),
    .var_value_o    (var_value_o),
    .freelitcnt_pre (freelitcnt_pre),
    .freelitcnt_next(freelitcnt_next),
    .imp_drv_i      (imp_drv_i),
    .cclause_drv_i  (cclause_drv_i),
    .cclause_o      (cclause_o),
    .clausesat_o    (clausesat_o)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [1:0] v;
    logic [1:0] pre;
    logic       imp;
    logic       cc;
    logic [1:0] e_next;
    logic [2:0] e_vo;
    logic       e_cc;
    logic       e_sat;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input int idx,
                     input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    // rst wr v pre imp cc | next vo cc sat  (outputs use lit before edge)
    tv.push_back('{0,0,2'b10,2'b01,1,1, 2'b01,3'b000,0,0}); // 0 after reset
    tv.push_back('{0,1,2'b10,2'b00,0,0, 2'b00,3'b000,0,0}); // write pos
    tv.push_back('{0,0,2'b00,2'b00,0,0, 2'b01,3'b000,0,0});
    tv.push_back('{0,0,2'b01,2'b01,0,0, 2'b01,3'b000,0,0});
    tv.push_back('{0,0,2'b00,2'b01,0,0, 2'b11,3'b000,0,0});
    tv.push_back('{0,0,2'b00,2'b01,0,0, 2'b11,3'b000,0,0}); // 5
    tv.push_back('{0,0,2'b00,2'b11,0,0, 2'b11,3'b000,0,0});
    tv.push_back('{0,0,2'b00,2'b10,0,0, 2'b11,3'b000,0,0});
    tv.push_back('{0,0,2'b10,2'b01,0,0, 2'b01,3'b000,0,1});
    tv.push_back('{0,0,2'b11,2'b00,0,0, 2'b00,3'b000,0,0});
    tv.push_back('{0,0,2'b00,2'b00,1,0, 2'b01,3'b101,0,0}); // 10
    tv.push_back('{0,0,2'b01,2'b00,0,1, 2'b00,3'b000,1,0});
    tv.push_back('{0,1,2'b01,2'b00,0,0, 2'b00,3'b000,0,0}); // write neg
    tv.push_back('{0,0,2'b01,2'b00,0,0, 2'b00,3'b000,0,1});
    tv.push_back('{0,0,2'b10,2'b00,0,0, 2'b00,3'b000,0,0});
    tv.push_back('{0,0,2'b00,2'b00,1,0, 2'b01,3'b011,0,0}); // 15
    tv.push_back('{0,0,2'b01,2'b00,1,0, 2'b00,3'b000,0,1});
    tv.push_back('{0,0,2'b00,2'b01,1,1, 2'b11,3'b011,1,0});
    tv.push_back('{0,1,2'b00,2'b00,0,1, 2'b01,3'b000,1,0}); // write 00
    tv.push_back('{0,0,2'b00,2'b01,1,1, 2'b01,3'b000,0,0});
    tv.push_back('{0,1,2'b10,2'b11,0,0, 2'b11,3'b000,0,0}); // 20 write pos
    tv.push_back('{0,1,2'b11,2'b00,0,0, 2'b00,3'b000,0,0}); // write 11
    tv.push_back('{0,0,2'b00,2'b11,1,1, 2'b11,3'b000,0,0});
    tv.push_back('{0,0,2'b10,2'b10,0,1, 2'b10,3'b000,0,0});
    tv.push_back('{0,0,2'b01,2'b01,0,1, 2'b01,3'b000,0,0});
    tv.push_back('{0,0,2'b11,2'b00,0,1, 2'b00,3'b000,0,0}); // 25
    tv.push_back('{0,1,2'b01,2'b00,0,0, 2'b00,3'b000,0,0}); // write neg
    tv.push_back('{1,1,2'b10,2'b00,0,1, 2'b00,3'b000,1,0}); // rst+wr
    tv.push_back('{0,0,2'b10,2'b01,0,1, 2'b01,3'b000,0,0});
    tv.push_back('{0,1,2'b10,2'b00,0,0, 2'b00,3'b000,0,0}); // write pos
    tv.push_back('{1,0,2'b10,2'b00,0,0, 2'b00,3'b000,0,1}); // 30 mid rst
    tv.push_back('{0,0,2'b10,2'b00,0,1, 2'b00,3'b000,0,0});

    rst = 1'b1; wr_i = 1'b0; var_value_i = 3'b000;
    freelitcnt_pre = 2'b00; imp_drv_i = 1'b0; cclause_drv_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst            = tv[i].rst;
      wr_i           = tv[i].wr;
      // Implied flag toggled to show it is ignored.
      var_value_i    = {tv[i].v, i[0]};
      freelitcnt_pre = tv[i].pre;
      imp_drv_i      = tv[i].imp;
      cclause_drv_i  = tv[i].cc;
      #1;
      chk("freelitcnt_next", i, {1'b0, freelitcnt_next},
          {1'b0, tv[i].e_next});
      chk("var_value_o", i, var_value_o, tv[i].e_vo);
      chk("cclause_o", i, {2'b00, cclause_o}, {2'b00, tv[i].e_cc});
      chk("clausesat_o", i, {2'b00, clausesat_o}, {2'b00, tv[i].e_sat});
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lit_cell.md
# lit_cell

One literal slot of a clause row in the hardware SAT-solver clause array. It holds the literal's polarity and compares it with the current value of its variable. It produces a daisy-chained free-literal count, a clause-satisfied flag, the implication value to drive back to the variable, and the conflict-clause participation flag. Cells are chained left-to-right along a clause; the clause controller consumes the final count and drives `imp_drv_i` and `cclause_drv_i`.

## Interface
Parameters: none.
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_i`  in  1  write strobe; loads the literal from `var_value_i[2:1]`
- `var_value_i`  in  3  `[2:1]` variable value (00 free, 01 false, 10 true, 11 conflict); `[0]` implied flag, ignored by this cell
- `var_value_o`  out  3  implication request to the variable: `[2:1]` value, `[0]` implied strobe
- `freelitcnt_pre`  in  2  free-literal count from the previous cell (00 none, 01 one, 11 two or more)
- `freelitcnt_next`  out  2  count passed to the next cell
- `imp_drv_i`  in  1  clause is unit; the free literal must be implied
- `cclause_drv_i`  in  1  clause is the conflict clause
- `cclause_o`  out  1  this literal participates in the conflict clause
- `clausesat_o`  out  1  this literal is true

## Operation
- State: `lit[1:0]`, with encoding 00 empty, 01 negative literal, 10 positive literal. Code 11 is never stored.
- Write: on a rising edge with `wr_i`=1, `lit` <= `var_value_i[2:1]`. A write of 11 stores 00. With `wr_i`=0, `lit` holds.
- Literal status, with `v` = `var_value_i[2:1]` and `lit` non-empty:
  - true when `v`==`lit`
  - free when `v`==00
  - false otherwise; a conflict value of 11 counts as false
- An empty `lit` is never true, free or false.
- `freelitcnt_next`:
  - literal free: `{pre[1]|pre[0], 1'b1}`, giving 00→01, 01→11, 11→11, 10→11
  - otherwise: `freelitcnt_pre` unchanged
- `clausesat_o` = literal true.
- `var_value_o`:
  - `imp_drv_i`=1 and literal free: `{lit, 1'b1}` (positive → 101, negative → 011)
  - otherwise: 000
- `cclause_o` = `cclause_drv_i` & (`lit` != 00).

## Timing
- All outputs are purely combinational from `lit` and the current inputs; zero-cycle latency.
- `lit` changes only at a clock edge. During the write cycle, outputs still reflect the old `lit`; the new `lit` is visible from the following cycle.
- Reset: `lit`=00 and takes priority over `wr_i`. After reset, outputs are:
  - `freelitcnt_next` = `freelitcnt_pre`
  - `var_value_o` = 000
  - `cclause_o` = 0
  - `clausesat_o` = 0
- Asserting `rst` mid-operation clears `lit` at the next edge regardless of the other inputs.
- `imp_drv_i` and `cclause_drv_i` may be high together; the two outputs are independent.

## Structure
- Shared package `sat_pkg`:
  - variable-value constants `VAL_FREE`=2'b00, `VAL_FALSE`=2'b01, `VAL_TRUE`=2'b10, `VAL_CONFLICT`=2'b11
  - literal constants `LIT_NONE`, `LIT_NEG`, `LIT_POS`
  - free-count constants `CNT_ZERO`=2'b00, `CNT_ONE`=2'b01, `CNT_MANY`=2'b11
  - a function `freecnt_inc`
- No sub-module; a single flat module with one 2-bit register and combinational decode.

## Test plan
- Reset, then `freelitcnt_pre`=01 with any `var_value_i` → `freelitcnt_next`=01, `clausesat_o`=0, `var_value_o`=000, `cclause_o`=0.
- Write 10 (positive); `v`=00, pre=00 → next=01. `v`=01, pre=01 → next=01, `clausesat_o`=0. `v`=00, pre=01 → next=11, repeated twice.
- Positive literal, `v`=10 → `clausesat_o`=1, next=pre. Negative literal (write 01), `v`=01 → `clausesat_o`=1; `v`=10 → `clausesat_o`=0.
- Negative literal, `v`=00, `imp_drv_i`=1 → `var_value_o`=011; with `v`=01 → 000.
- Literal present, `cclause_drv_i`=1 → `cclause_o`=1. Rewrite with 00, then with 11 → `cclause_o`=0, next=pre for all `v`.
- `wr_i` and `rst` high in the same cycle → `lit`=00 afterwards. Outputs during a write cycle reflect the old literal.
